// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read/write port bundle for the multi-port register file
interface regfile_mp_if #(
  parameter int W  = 32,
  parameter int AW = 5,
  parameter int NR = 2
);
  logic [NR*AW-1:0] ReadAddr;
  logic [NR*W-1:0]  ReadData;
  logic             WriteEnA;
  logic [AW-1:0]    WriteRegA;
  logic [W-1:0]     WriteDataA;
  logic             WriteEnB;
  logic [AW-1:0]    WriteRegB;
  logic [W-1:0]     WriteDataB;
  logic             Busy;
  modport master (
    output ReadAddr, WriteEnA, WriteRegA, WriteDataA, WriteEnB, WriteRegB, WriteDataB,
    input  ReadData, Busy
  );
  modport slave (
    input  ReadAddr, WriteEnA, WriteRegA, WriteDataA, WriteEnB, WriteRegB, WriteDataB,
    output ReadData, Busy
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: NR combinational read ports, two prioritised write ports, post-reset clear sweep
module regfile_mp #(
  parameter int W        = 32,
  parameter int AW       = 5,
  parameter int NR       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clock,
  input logic         reset_n,
  regfile_mp_if.slave bus
);
  localparam int            DEPTH   = 1 << AW;
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [0:0]    S_CLEAR = 1'b0;
  localparam logic [0:0]    S_IDLE  = 1'b1;
  logic [0:0]    r_state;
  logic [AW-1:0] r_ptr;
  logic [W-1:0]  r_mem [DEPTH];
  logic          w_busy;
  logic          w_wa;
  logic          w_wb;
  logic [AW-1:0] w_a;
  assign w_busy  = (r_state == S_CLEAR);
  assign bus.Busy = w_busy;
  assign w_wa = !w_busy && bus.WriteEnA && (ZERO_REG == 0 || bus.WriteRegA != '0);
  assign w_wb = !w_busy && bus.WriteEnB && (ZERO_REG == 0 || bus.WriteRegB != '0);
  // pointer parks on the last entry so the sweep never wraps
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
    end else if (w_busy) begin
      if (r_ptr == LAST) r_state <= S_IDLE;
      else r_ptr <= r_ptr + 1'b1;
    end
  end
  // B is assigned last so it overrides A on an address collision
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (w_busy) r_mem[r_ptr] <= '0;
      if (w_wa) r_mem[bus.WriteRegA] <= bus.WriteDataA;
      if (w_wb) r_mem[bus.WriteRegB] <= bus.WriteDataB;
    end
  end
  always_comb begin
    bus.ReadData = '0;
    w_a = '0;
    for (int k = 0; k < NR; k++) begin
      w_a = bus.ReadAddr[k*AW +: AW];
      bus.ReadData[k*W +: W] =
        w_busy                                                          ? '0 :
        (ZERO_REG != 0 && w_a == '0)                                    ? '0 :
        (BYPASS != 0 && bus.WriteEnB && bus.WriteRegB == w_a) ? bus.WriteDataB :
        (BYPASS != 0 && bus.WriteEnA && bus.WriteRegA == w_a) ? bus.WriteDataA :
                                                                  r_mem[w_a];
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: bypass/no-bypass 32x32 builds against a reference model, plus an 8x8 four-port build
module tb_regfile_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst_n, rst2;
  logic [9:0]  ra;
  logic        wea, web;
  logic [4:0]  wra, wrb;
  logic [31:0] wda, wdb;
  logic [11:0] ra2;
  logic        wea2, web2;
  logic [2:0]  wra2, wrb2;
  logic [7:0]  wda2, wdb2;
  regfile_mp_if #(.W(32), .AW(5), .NR(2)) ia ();
  regfile_mp_if #(.W(32), .AW(5), .NR(2)) ib ();
  regfile_mp_if #(.W(8),  .AW(3), .NR(4)) ic ();
  assign ia.ReadAddr = ra;  assign ia.WriteEnA = wea; assign ia.WriteRegA = wra; assign ia.WriteDataA = wda;
  assign ia.WriteEnB = web; assign ia.WriteRegB = wrb; assign ia.WriteDataB = wdb;
  assign ib.ReadAddr = ra;  assign ib.WriteEnA = wea; assign ib.WriteRegA = wra; assign ib.WriteDataA = wda;
  assign ib.WriteEnB = web; assign ib.WriteRegB = wrb; assign ib.WriteDataB = wdb;
  assign ic.ReadAddr = ra2;  assign ic.WriteEnA = wea2; assign ic.WriteRegA = wra2; assign ic.WriteDataA = wda2;
  assign ic.WriteEnB = web2; assign ic.WriteRegB = wrb2; assign ic.WriteDataB = wdb2;
  regfile_mp #(.W(32), .AW(5), .NR(2), .ZERO_REG(1), .BYPASS(1)) dut_a (.clock(clk), .reset_n(rst_n), .bus(ia));
  regfile_mp #(.W(32), .AW(5), .NR(2), .ZERO_REG(1), .BYPASS(0)) dut_b (.clock(clk), .reset_n(rst_n), .bus(ib));
  regfile_mp #(.W(8),  .AW(3), .NR(4), .ZERO_REG(0), .BYPASS(1)) dut_c (.clock(clk), .reset_n(rst2),  .bus(ic));
  int total = 0;
  int bad = 0;
  // reference: edges since reset release and the architectural contents
  int          cnt = 0;
  logic [31:0] mem [32];
  typedef struct {
    logic wea; logic [4:0] wra; logic [31:0] wda;
    logic web; logic [4:0] wrb; logic [31:0] wdb;
    logic [4:0] a0, a1; logic [31:0] e0, e1;
  } vec_t;
  vec_t tbl [8];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  function automatic logic [31:0] exp_rd(input bit bp, input logic [4:0] a);
    if (cnt < 32 || a == 5'd0) return 32'd0;
    if (bp && web && wrb == a) return wdb;
    if (bp && wea && wra == a) return wda;
    return mem[a];
  endfunction
  task automatic step();
    @(posedge clk);
    if (!rst_n) cnt = 0;
    else if (cnt < 32) begin
      cnt++;
      if (cnt == 32) for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    end else begin
      if (wea && wra != 5'd0) mem[wra] = wda;
      if (web && wrb != 5'd0) mem[wrb] = wdb;
    end
    #1;
  endtask
  task automatic check_all();
    #1;
    chk("busy_byp", 32'(ia.Busy), 32'(cnt < 32));
    chk("busy_nobyp", 32'(ib.Busy), 32'(cnt < 32));
    for (int k = 0; k < 2; k++) begin
      chk("rd_byp", ia.ReadData[k*32 +: 32], exp_rd(1'b1, ra[k*5 +: 5]));
      chk("rd_nobyp", ib.ReadData[k*32 +: 32], exp_rd(1'b0, ra[k*5 +: 5]));
    end
  endtask
  task automatic idle();
    wea = 0; web = 0; wra = 0; wrb = 0; wda = 0; wdb = 0;
  endtask
  initial begin
    int n;
    tbl[0] = '{1'b1, 5'd5,  32'h11,       1'b1, 5'd5, 32'h22,   5'd5,  5'd0,  32'h22,       32'h0};
    tbl[1] = '{1'b1, 5'd6,  32'h33,       1'b1, 5'd7, 32'h44,   5'd5,  5'd6,  32'h22,       32'h33};
    tbl[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,    5'd6,  5'd7,  32'h33,       32'h44};
    tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,    5'd0,  5'd31, 32'h0,        32'h0};
    tbl[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,    5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,    5'd31, 5'd0,  32'hFFFFFFFF, 32'h0};
    tbl[6] = '{1'b1, 5'd10, 32'h1,        1'b1, 5'd9, 32'hABCD, 5'd10, 5'd9,  32'h1,        32'hABCD};
    tbl[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,    5'd9,  5'd10, 32'hABCD,     32'h1};
    rst_n = 0; rst2 = 0; ra = 0; idle();
    ra2 = 0; wea2 = 0; web2 = 0; wra2 = 0; wrb2 = 0; wda2 = 0; wdb2 = 0;
    step(); step();
    check_all();
    rst_n = 1;
    n = 0;
    while (ia.Busy && n < 100) begin
      ra = 10'($urandom);
      check_all();
      step();
      n++;
    end
    chk("clear_len", 32'(n), 32'd32);
    for (int i = 0; i < 32; i++) begin
      ra = {5'(i), 5'(i)};
      check_all();
      chk("after_clear", ia.ReadData[31:0], 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      wea = tbl[i].wea; wra = tbl[i].wra; wda = tbl[i].wda;
      web = tbl[i].web; wrb = tbl[i].wrb; wdb = tbl[i].wdb;
      ra = {tbl[i].a1, tbl[i].a0};
      check_all();
      chk("tbl_p0", ia.ReadData[31:0], tbl[i].e0);
      chk("tbl_p1", ia.ReadData[63:32], tbl[i].e1);
      step();
    end
    idle();
    for (int i = 1; i < 32; i++) begin
      wea = 1; wra = 5'(i); wda = 32'd10; ra = {5'(i), 5'(i)};
      check_all();
      step();
    end
    wra = 0; wda = 32'hFFFFFFFF;
    step();
    idle();
    for (int i = 0; i < 31; i++) begin
      ra = {5'(i + 1), 5'(i)};
      check_all();
      chk("sweep_p0", ib.ReadData[31:0], (i == 0) ? 32'd0 : 32'd10);
      chk("sweep_p1", ib.ReadData[63:32], 32'd10);
    end
    rst_n = 0; step();
    rst_n = 1;
    repeat (10) step();
    rst_n = 0; wea = 1; wra = 5'd3; wda = 32'd77;
    step();
    idle(); rst_n = 1;
    n = 0;
    while (ia.Busy && n < 100) begin
      if (n == 5) begin wea = 1; wra = 5'd3; wda = 32'd99; end else idle();
      ra = {5'd3, 5'd3};
      check_all();
      step();
      n++;
    end
    chk("reclear_len", 32'(n), 32'd32);
    idle(); ra = {5'd3, 5'd3};
    check_all();
    chk("busy_write_dropped", ia.ReadData[31:0], 32'd0);
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      wea = 1'($urandom); web = 1'($urandom);
      wra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wrb = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wda = $urandom; wdb = $urandom;
      ra = {5'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7))};
      check_all();
      step();
    end
    rst_n = 1; idle();
    rst2 = 1;
    n = 0;
    while (ic.Busy && n < 50) begin step(); n++; end
    chk("small_clear_len", 32'(n), 32'd8);
    wea2 = 1; wra2 = 3'd0; wda2 = 8'hA5;
    step();
    wea2 = 0; ra2 = 12'd0;
    #1;
    for (int k = 0; k < 4; k++) chk("small_r0", 32'(ic.ReadData[k*8 +: 8]), 32'hA5);
    wea2 = 1; wra2 = 3'd1; wda2 = 8'h11; web2 = 1; wrb2 = 3'd2; wdb2 = 8'h22;
    step();
    wra2 = 3'd3; wda2 = 8'h33; wrb2 = 3'd4; wdb2 = 8'h5A;
    ra2 = {3'd4, 3'd3, 3'd2, 3'd1};
    #1;
    chk("small_p0", 32'(ic.ReadData[7:0]),   32'h11);
    chk("small_p1", 32'(ic.ReadData[15:8]),  32'h22);
    chk("small_p2", 32'(ic.ReadData[23:16]), 32'h33);
    chk("small_p3", 32'(ic.ReadData[31:24]), 32'h5A);
    step();
    wra2 = 3'd6; wda2 = 8'h01; wrb2 = 3'd6; wdb2 = 8'h02;
    step();
    wea2 = 0; web2 = 0;
    ra2 = {3'd6, 3'd0, 3'd4, 3'd3};
    #1;
    chk("small_q0", 32'(ic.ReadData[7:0]),   32'h33);
    chk("small_q1", 32'(ic.ReadData[15:8]),  32'h5A);
    chk("small_q2", 32'(ic.ReadData[23:16]), 32'hA5);
    chk("small_coll", 32'(ic.ReadData[31:24]), 32'h02);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
